// File: rtl/prio_serializer_if.sv
// Stream bundle for prio_serializer: a vector input stream and a per-bit entry output stream.
// The design uses the slave modport; the producer/consumer side uses master.
interface prio_serializer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic       out_last;
  logic [2:0] out_seq;
  logic       busy;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_last, out_seq, busy
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_last, out_seq, busy
  );
endinterface

// File: rtl/prio_serializer.sv
// Serializes an 8-bit request vector into one entry per set bit, highest index first.
// Outputs come straight from the pending register, so they hold still while stalled.
module prio_serializer (
  input  logic             clk,
  input  logic             rst_n,
  prio_serializer_if.slave bus
);
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t     state_reg, state_next;
  logic [7:0] pending_reg, pending_next;
  logic [2:0] seq_reg, seq_next;

  logic [7:0] above;
  logic [7:0] top_onehot;
  logic [2:0] top_idx;
  logic       is_last;
  logic       drain;
  logic       xfer;
  logic       hs;

  // above[gi] is set when any higher-priority bit is still pending
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pick
      if (gi == 7) begin : g_top
        assign above[gi] = 1'b0;
      end else begin : g_rest
        assign above[gi] = |pending_reg[7:gi+1];
      end
      assign top_onehot[gi] = pending_reg[gi] & ~above[gi];
    end
  endgenerate

  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (top_onehot[i]) top_idx = 3'(i);
    end
  end

  assign is_last = (pending_reg & ~top_onehot) == 8'h00;
  assign drain   = (state_reg == DRAIN);

  assign bus.out_valid  = drain;
  assign bus.busy       = drain;
  assign bus.out_onehot = drain ? top_onehot : 8'h00;
  assign bus.out_idx    = drain ? top_idx : 3'd0;
  assign bus.out_seq    = drain ? seq_reg : 3'd0;
  assign bus.out_last   = drain & is_last;
  // In DRAIN a new vector is only taken on the beat that empties the current one
  assign bus.in_ready   = ~drain | (bus.out_ready & is_last);

  assign xfer = bus.in_valid & bus.in_ready;
  assign hs   = drain & bus.out_ready;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    seq_next     = seq_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          pending_next = bus.in_vec;
          seq_next     = 3'd0;
          state_next   = (bus.in_vec != 8'h00) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (hs) begin
          if (is_last) begin
            seq_next = 3'd0;
            if (xfer && bus.in_vec != 8'h00) begin
              pending_next = bus.in_vec;
              state_next   = DRAIN;
            end else begin
              pending_next = 8'h00;
              state_next   = IDLE;
            end
          end else begin
            pending_next = pending_reg & ~top_onehot;
            seq_next     = seq_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = 8'h00;
        seq_next     = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= 8'h00;
      seq_reg     <= 3'd0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      seq_reg     <= seq_next;
    end
  end
endmodule

// File: tb/tb_prio_serializer.sv
// Bench for prio_serializer: a queue model of expected entries checked every cycle,
// plus directed scenarios with literal expected beat sequences.
module tb_prio_serializer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  prio_serializer_if bus ();

  prio_serializer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int seq; int last;} beat_t;
  typedef struct {int idx; int onehot; int seq; int last;} obs_t;

  beat_t exp_q[$];
  obs_t  log_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: pending entries as a queue; each accepted vector expands into its set bits
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        bit        rdy;
        bit        hs;
        logic [7:0] v;
        rdy = (exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1);
        hs  = (exp_q.size() > 0) && bus.out_ready;
        v   = bus.in_vec;
        if (hs) void'(exp_q.pop_front());
        if (bus.in_valid && rdy) begin
          int n;
          int s;
          n = $countones(v);
          s = 0;
          for (int b = 7; b >= 0; b--) begin
            if (v[b]) begin
              exp_q.push_back('{b, s, (s == n - 1) ? 1 : 0});
              s++;
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle the DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          chk("m_out_valid", 32'(bus.out_valid), 0);
          chk("m_busy", 32'(bus.busy), 0);
          chk("m_in_ready", 32'(bus.in_ready), 1);
          chk("m_idle_fields", {bus.out_onehot, 5'd0, bus.out_idx, 5'd0, bus.out_seq, 7'd0, bus.out_last}, 0);
        end else begin
          chk("m_out_valid", 32'(bus.out_valid), 1);
          chk("m_busy", 32'(bus.busy), 1);
          chk("m_out_idx", 32'(bus.out_idx), 32'(exp_q[0].idx));
          chk("m_out_onehot", 32'(bus.out_onehot), 32'(1) << exp_q[0].idx);
          chk("m_out_seq", 32'(bus.out_seq), 32'(exp_q[0].seq));
          chk("m_out_last", 32'(bus.out_last), 32'(exp_q[0].last));
          chk("m_in_ready", 32'(bus.in_ready), (bus.out_ready && exp_q.size() == 1) ? 1 : 0);
        end
      end
    end
  end

  // Record each completed beat for literal comparison per scenario
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
        log_q.push_back('{int'(bus.out_idx), int'(bus.out_onehot), int'(bus.out_seq), int'(bus.out_last)});
    end
  end

  task automatic exp_beat(input string nm, input int i, input int idx, input int oh, input int seq, input int last);
    if (i >= log_q.size()) begin
      chk({nm, "_present"}, 32'(log_q.size()), 32'(i + 1));
    end else begin
      chk({nm, "_idx"}, 32'(log_q[i].idx), 32'(idx));
      chk({nm, "_onehot"}, 32'(log_q[i].onehot), 32'(oh));
      chk({nm, "_seq"}, 32'(log_q[i].seq), 32'(seq));
      chk({nm, "_last"}, 32'(log_q[i].last), 32'(last));
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk({nm, "_timeout"}, 32'(n), 0);
  endtask

  task automatic send(input logic [7:0] v);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rvec [4];
    rvec[0] = 8'h5A; rvec[1] = 8'h00; rvec[2] = 8'h81; rvec[3] = 8'h3C;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vec = 8'h00;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk_en = 1'b1;

    // 1010_0100 with consumer always ready
    log_q.delete();
    bus.out_ready = 1'b1;
    send(8'hA4);
    wait_idle("a4");
    repeat (2) tick();
    chk("a4_count", 32'(log_q.size()), 3);
    exp_beat("a4_b0", 0, 7, 8'h80, 0, 0);
    exp_beat("a4_b1", 1, 5, 8'h20, 1, 0);
    exp_beat("a4_b2", 2, 2, 8'h04, 2, 1);

    // zero vector is swallowed
    log_q.delete();
    send(8'h00);
    chk("zero_out_valid", 32'(bus.out_valid), 0);
    chk("zero_in_ready", 32'(bus.in_ready), 1);
    tick();
    chk("zero_count", 32'(log_q.size()), 0);

    // stall on 8'h12; in_vec churn while not ready must be ignored
    log_q.delete();
    bus.out_ready = 1'b0;
    send(8'h12);
    for (int c = 0; c < 4; c++) begin
      chk("stall_idx", 32'(bus.out_idx), 4);
      chk("stall_onehot", 32'(bus.out_onehot), 8'h10);
      bus.in_valid = 1'b1;
      bus.in_vec   = 8'hFF;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("stall");
    chk("stall_count", 32'(log_q.size()), 2);
    exp_beat("stall_b0", 0, 4, 8'h10, 0, 0);
    exp_beat("stall_b1", 1, 1, 8'h02, 1, 1);

    // back-to-back vector on the last handshake
    log_q.delete();
    bus.in_valid = 1'b1;
    bus.in_vec   = 8'h01;
    tick();
    bus.in_vec   = 8'hC0;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_no_bubble", 32'(bus.out_valid), 1);
    chk("b2b_seq0", 32'(bus.out_seq), 0);
    wait_idle("b2b");
    chk("b2b_count", 32'(log_q.size()), 3);
    exp_beat("b2b_b0", 0, 0, 8'h01, 0, 1);
    exp_beat("b2b_b1", 1, 7, 8'h80, 0, 0);
    exp_beat("b2b_b2", 2, 6, 8'h40, 1, 1);

    // full vector: eight beats, seq reaches 7
    log_q.delete();
    send(8'hFF);
    wait_idle("ff");
    chk("ff_count", 32'(log_q.size()), 8);
    for (int k = 0; k < 8; k++)
      exp_beat("ff_b", k, 7 - k, 1 << (7 - k), k, (k == 7) ? 1 : 0);

    // reset mid-drain discards the rest of the vector
    log_q.delete();
    send(8'hFF);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_out_valid", 32'(bus.out_valid), 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_in_ready", 32'(bus.in_ready), 1);
    repeat (5) tick();
    chk("mrst_count", 32'(log_q.size()), 2);
    exp_beat("mrst_b0", 0, 7, 8'h80, 0, 0);
    exp_beat("mrst_b1", 1, 6, 8'h40, 1, 0);

    // random back-pressure, model-checked
    for (int v = 0; v < 4; v++) begin
      int n;
      send(rvec[v]);
      n = 0;
      while (bus.out_valid && n < 100) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      if (n >= 100) chk("rand_timeout", 32'(n), 0);
    end
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
